// File: rtl/burst_reverse_buffer_if.sv
// rtl/burst_reverse_buffer_if.sv - burst source / consumer signal bundle for burst_reverse_buffer
interface burst_reverse_buffer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              mode;
    logic              i_valid;
    logic [DATA_W-1:0] Din;
    logic              busy;
    logic [DATA_W-1:0] Dout;
    logic              o_valid;
    logic              o_last;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    // Upstream source plus downstream consumer side
    modport master (
        output mode, i_valid, Din, busy,
        input  Dout, o_valid, o_last, full, count, overflow
    );

    // Buffer side
    modport slave (
        input  mode, i_valid, Din, busy,
        output Dout, o_valid, o_last, full, count, overflow
    );
endinterface

// File: rtl/burst_reverse_buffer.sv
// rtl/burst_reverse_buffer.sv - captures a burst and replays it in LIFO or FIFO order
module burst_reverse_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    burst_reverse_buffer_if.slave bus
);
    localparam int ADDR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W-1:0]  rd_idx;
    logic               mode_q;
    logic               overflow_q;
    logic               o_valid_q;
    logic               o_last_q;
    logic [DATA_W-1:0]  dout_q;

    logic               full_w;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;

    assign full_w = (count_q == DEPTH_C);

    // Write port: first word of a burst lands at 0, later words at the current count
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (bus.i_valid) begin
            if (state == IDLE) begin
                wr_en = 1'b1;
            end else if (state == LOAD && !full_w) begin
                wr_en   = 1'b1;
                wr_addr = count_q[ADDR_W-1:0];
            end
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.Din;
        end
    end

    // Control FSM with registered outputs; outputs default low every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count_q    <= '0;
            rd_idx     <= '0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            dout_q    <= '0;
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        count_q    <= CNT_W'(1);
                        mode_q     <= bus.mode;
                        overflow_q <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.i_valid) begin
                        if (!full_w) begin
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else if (!bus.busy) begin
                        state <= DRAIN;
                        // count is DEPTH when full; its low bits wrap to 0 so -1 still yields DEPTH-1
                        rd_idx <= mode_q ? '0 : (count_q[ADDR_W-1:0] - ADDR_W'(1));
                    end
                end
                DRAIN: begin
                    if (bus.i_valid) begin
                        overflow_q <= 1'b1;
                    end
                    if (count_q == '0) begin
                        state <= IDLE;
                    end else if (!bus.busy) begin
                        o_valid_q <= 1'b1;
                        dout_q    <= mem[rd_idx];
                        o_last_q  <= (count_q == CNT_W'(1));
                        count_q   <= count_q - CNT_W'(1);
                        rd_idx    <= mode_q ? (rd_idx + ADDR_W'(1)) : (rd_idx - ADDR_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_last   = o_last_q;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_burst_reverse_buffer.sv
// tb/tb_burst_reverse_buffer.sv - directed self-checking bench for burst_reverse_buffer
module tb_burst_reverse_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    burst_reverse_buffer_if #(.DATA_W(8), .CNT_W(5)) bus ();

    burst_reverse_buffer #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.i_valid = 1'b1;
        bus.Din     = d;
        tick();
        bus.i_valid = 1'b0;
        bus.Din     = 8'h00;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic last);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_dout"},  32'(bus.Dout),    32'(d));
        check({tag, "_last"},  32'(bus.o_last),  32'(last));
    endtask

    task automatic expect_idle_out(input string tag);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_dout"},  32'(bus.Dout),    32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        bus.mode    = 1'b0;
        bus.i_valid = 1'b0;
        bus.Din     = 8'h00;
        bus.busy    = 1'b0;
        #12;
        check("rst_valid",    32'(bus.o_valid),  32'd0);
        check("rst_last",     32'(bus.o_last),   32'd0);
        check("rst_dout",     32'(bus.Dout),     32'd0);
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        tick();

        // LIFO basic
        bus.mode = 1'b0;
        wr(8'h11);
        check("lifo_cnt1", 32'(bus.count), 32'd1);
        wr(8'h22);
        wr(8'h33);
        check("lifo_cnt3", 32'(bus.count), 32'd3);
        tick();
        expect_idle_out("lifo_e1");
        tick();
        expect_out("lifo_o0", 8'h33, 1'b0);
        check("lifo_cnt_o0", 32'(bus.count), 32'd2);
        tick();
        expect_out("lifo_o1", 8'h22, 1'b0);
        tick();
        expect_out("lifo_o2", 8'h11, 1'b1);
        check("lifo_cnt_o2", 32'(bus.count), 32'd0);
        tick();
        expect_idle_out("lifo_end");
        check("lifo_end_last", 32'(bus.o_last), 32'd0);

        // FIFO basic; mode flips mid-burst and must be ignored
        tick();
        bus.mode = 1'b1;
        wr(8'h11);
        bus.mode = 1'b0;
        wr(8'h22);
        wr(8'h33);
        tick();
        tick();
        expect_out("fifo_o0", 8'h11, 1'b0);
        tick();
        expect_out("fifo_o1", 8'h22, 1'b0);
        tick();
        expect_out("fifo_o2", 8'h33, 1'b1);
        tick();
        expect_idle_out("fifo_end");

        // Full / overflow: 18 words into a 16-deep buffer, LIFO replay
        tick();
        bus.mode = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr(8'(i));
            if (i == 15) begin
                check("full_after16", 32'(bus.full),     32'd1);
                check("cnt_after16",  32'(bus.count),    32'd16);
                check("ovf_after16",  32'(bus.overflow), 32'd0);
            end
        end
        check("full_after18", 32'(bus.full),     32'd1);
        check("cnt_after18",  32'(bus.count),    32'd16);
        check("ovf_after18",  32'(bus.overflow), 32'd1);
        tick();
        expect_idle_out("full_e1");
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_out($sformatf("full_o%0d", i), 8'(15 - i), (i == 15));
        end
        tick();
        expect_idle_out("full_end");
        check("full_end_ovf",  32'(bus.overflow), 32'd1);
        check("full_end_full", 32'(bus.full),     32'd0);

        // Busy stall after the second output of a 4-word LIFO burst
        tick();
        wr(8'hA0);
        check("stall_ovf_clr", 32'(bus.overflow), 32'd0);
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        tick();
        tick();
        expect_out("stall_o0", 8'hA3, 1'b0);
        tick();
        expect_out("stall_o1", 8'hA2, 1'b0);
        bus.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle_out($sformatf("stall_b%0d", i));
            check($sformatf("stall_cnt%0d", i), 32'(bus.count), 32'd2);
        end
        bus.busy = 1'b0;
        tick();
        expect_out("stall_o2", 8'hA1, 1'b0);
        tick();
        expect_out("stall_o3", 8'hA0, 1'b1);
        tick();
        expect_idle_out("stall_end");

        // Wait for not-busy before entering DRAIN (FIFO burst)
        tick();
        bus.mode = 1'b1;
        wr(8'h5A);
        wr(8'h5B);
        bus.busy = 1'b1;
        tick();
        tick();
        expect_idle_out("wait_hold");
        check("wait_cnt", 32'(bus.count), 32'd2);
        bus.busy = 1'b0;
        tick();
        expect_idle_out("wait_e1");
        tick();
        expect_out("wait_o0", 8'h5A, 1'b0);
        tick();
        expect_out("wait_o1", 8'h5B, 1'b1);
        // Word offered at the closing DRAIN edge is dropped and flagged
        bus.i_valid = 1'b1;
        bus.Din     = 8'h77;
        tick();
        bus.i_valid = 1'b0;
        expect_idle_out("late_end");
        check("late_ovf", 32'(bus.overflow), 32'd1);
        check("late_cnt", 32'(bus.count),    32'd0);
        tick();
        check("late_cnt2", 32'(bus.count), 32'd0);

        // Asynchronous reset in the middle of DRAIN
        bus.mode = 1'b0;
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        tick();
        tick();
        expect_out("rstd_o0", 8'h03, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_idle_out("rstd_now");
        check("rstd_cnt", 32'(bus.count),    32'd0);
        check("rstd_ovf", 32'(bus.overflow), 32'd0);
        #3;
        reset = 1'b1;
        tick();
        bus.mode = 1'b1;
        wr(8'hC1);
        wr(8'hC2);
        check("post_cnt", 32'(bus.count),    32'd2);
        check("post_ovf", 32'(bus.overflow), 32'd0);
        tick();
        tick();
        expect_out("post_o0", 8'hC1, 1'b0);
        tick();
        expect_out("post_o1", 8'hC2, 1'b1);
        tick();
        expect_idle_out("post_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
